// File: rtl/wb_mem_arbiter_if.sv
// Pipelined Wishbone B4 bus bundle for the memory arbiter.
// master drives the request side; slave drives the response side.
interface wb_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW/8-1:0] sel;
    logic          ack;
    logic          err;
    logic          stall;
    logic [DW-1:0] dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  ack, err, stall, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output ack, err, stall, dat_r
    );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter (fetch=m0, LSU=m1).
// WB_ARB_RR_EN selects round-robin tie-break; default is fixed M1 priority.
module wb_mem_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int OUTW = 4
) (
    input  logic            clk,
    input  logic            rstn,
    wb_mem_arbiter_if.slave  m0,
    wb_mem_arbiter_if.slave  m1,
    wb_mem_arbiter_if.master s,
    output logic [1:0]      gnt,
    output logic            proto_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [OUTW-1:0] OUT_MAX = '1;

    state_t          state;
    state_t          state_nx;
    logic [OUTW-1:0] outst;
    logic            pick1;
    logic            inc;
    logic            dec;
    logic            drop;
    logic            perr_set;

    logic [AW-1:0]   adr_mux;
    logic [DW-1:0]   wdat_mux;
    logic [DW/8-1:0] sel_mux;

`ifdef WB_ARB_RR_EN
    logic last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last <= 1'b1;
        else if (state_nx == G0)
            last <= 1'b0;
        else if (state_nx == G1)
            last <= 1'b1;
    end

    // On a tie the master that was not served last wins
    always_comb pick1 = m1.cyc & (!m0.cyc | !last);
`else
    always_comb pick1 = m1.cyc;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (m0.cyc | m1.cyc) state_nx = pick1 ? G1 : G0;
            G0:   if (!m0.cyc) state_nx = m1.cyc ? G1 : IDLE;
            G1:   if (!m1.cyc) state_nx = m0.cyc ? G0 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        adr_mux  = '0;
        wdat_mux = '0;
        sel_mux  = '0;
        m0.stall = 1'b1;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.stall = 1'b1;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        unique case (state)
            G0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                adr_mux  = m0.adr;
                wdat_mux = m0.dat_w;
                sel_mux  = m0.sel;
                m0.stall = s.stall;
                m0.ack   = s.ack;
                m0.err   = s.err;
            end
            G1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                adr_mux  = m1.adr;
                wdat_mux = m1.dat_w;
                sel_mux  = m1.sel;
                m1.stall = s.stall;
                m1.ack   = s.ack;
                m1.err   = s.err;
            end
            default: ;
        endcase
        s.adr   = adr_mux;
        s.dat_w = wdat_mux;
        s.sel   = sel_mux;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
    end

    assign gnt = {state == G1, state == G0};

    assign inc  = s.stb & ~s.stall;
    assign dec  = s.ack | s.err;
    assign drop = ((state == G0) & ~m0.cyc) | ((state == G1) & ~m1.cyc);

    assign perr_set = (dec & (outst == '0))
                    | (drop & (outst != '0))
                    | (inc & ~dec & (outst == OUT_MAX));

    // A dropped cycle abandons whatever is still in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outst <= '0;
        end else if (drop) begin
            outst <= '0;
        end else if (inc & ~dec) begin
            if (outst != OUT_MAX)
                outst <= outst + 1'b1;
        end else if (dec & ~inc) begin
            if (outst != '0)
                outst <= outst - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            proto_err <= 1'b0;
        else if (perr_set)
            proto_err <= 1'b1;
    end
endmodule
